// File: rtl/cnu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnu_sched_pkg
// Brief    : Shared LDPC decoder definitions: row-scheduler FSM states,
//            ceil-log2 sizing helper and check-node message sizing.
// Revision : 1.0 - initial release
// ============================================================================
package cnu_sched_pkg;

  // Row-scheduler states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // ceil(log2(value)) with a floor of 1 so single-entry ranges still get a bit
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Total bits presented to one check-node unit per row
  function automatic int cnu_msg_bits(input int degree, input int msg_w);
    return degree * msg_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnu_dly_line.sv
`default_nettype none
// ============================================================================
// Module   : cnu_dly_line
// Brief    : Fixed-depth shift register used to align {valid, addr} of an
//            issued row with the CNU result write-back.
// Revision : 1.0 - initial release
// ============================================================================
module cnu_dly_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  if (DEPTH < 1) begin : g_bad_depth
    $error("cnu_dly_line: DEPTH must be at least 1");
  end

  // Shift every stage one place per clock; reset flushes all in-flight entries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= din;
      for (int i = DEPTH - 1; i > 0; i--) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign dout = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/cnu_sched.sv
`default_nettype none
// ============================================================================
// Module   : cnu_sched
// Brief    : Layered LDPC check-node row scheduler. Issues one row read per
//            unstalled cycle, tracks rows in flight through the memory read
//            and CNU latency, and only starts the next iteration once the
//            previous iteration's last row has been written back.
// Revision : 1.0 - initial release
// ============================================================================
module cnu_sched
  import cnu_sched_pkg::*;
#(
  parameter  int D       = 8,
  parameter  int data_w  = 8,
  parameter  int ROWS    = 16,
  parameter  int CNU_LAT = 2,
  parameter  int ITER_W  = 6,
  localparam int ROW_W   = clog2_min1(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] n_iter,
  input  logic              stall,
  output logic              rd_en,
  output logic [ROW_W-1:0]  rd_addr,
  output logic              cnu_vld,
  output logic              wr_en,
  output logic [ROW_W-1:0]  wr_addr,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy,
  output logic              done
);

  // One cycle of memory read latency plus the CNU pipeline
  localparam int               c_DLY      = 1 + CNU_LAT;
  // Enough bits to count every row that can be between issue and write-back
  localparam int               c_INF_W    = clog2_min1(CNU_LAT + 3);
  localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(ROWS - 1);

  if (CNU_LAT < 1) begin : g_bad_lat
    $error("cnu_sched: CNU_LAT must be at least 1");
  end
  if (cnu_msg_bits(D, data_w) < 1) begin : g_bad_msg
    $error("cnu_sched: D and data_w must both be positive");
  end

  sched_state_t        r_state;
  logic [ROW_W-1:0]    r_row;
  logic [ITER_W-1:0]   r_n_iter;
  logic [ITER_W-1:0]   r_iter_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_cnu_vld;
  logic [c_INF_W-1:0]  r_inflight;
  logic                w_issue;
  logic                w_last_wr;
  logic [ROW_W:0]      w_dly_in;
  logic [ROW_W:0]      w_dly_out;

  // A row is issued whenever the scheduler is running and memory is free
  assign w_issue   = (r_state == RUN) && !stall;
  // The final write-back of an iteration is the one that empties the pipe
  assign w_last_wr = wr_en && (r_inflight == c_INF_W'(1));

  // Main scheduler FSM with registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_n_iter   <= '0;
      r_iter_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_iter_cnt <= '0;
            r_n_iter   <= n_iter;
            r_row      <= '0;
            r_busy     <= 1'b1;
            if (n_iter != '0) begin
              r_state <= RUN;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            if (r_row == c_LAST_ROW) begin
              r_row   <= '0;
              r_state <= DRAIN;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (w_last_wr) begin
            if ((r_iter_cnt + 1'b1) < r_n_iter) begin
              r_iter_cnt <= r_iter_cnt + 1'b1;
              r_state    <= RUN;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Count rows issued but not yet written back, to detect the empty pipe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, wr_en})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // CNU input valid follows the memory read by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnu_vld <= 1'b0;
    end else begin
      r_cnu_vld <= w_issue;
    end
  end

  assign w_dly_in = {w_issue, r_row};

  cnu_dly_line #(
    .DEPTH (c_DLY),
    .WIDTH (ROW_W + 1)
  ) u_wb_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (w_dly_in),
    .dout (w_dly_out)
  );

  assign rd_en    = w_issue;
  assign rd_addr  = r_row;
  assign cnu_vld  = r_cnu_vld;
  assign wr_en    = w_dly_out[ROW_W];
  assign wr_addr  = w_dly_out[ROW_W-1:0];
  assign iter_cnt = r_iter_cnt;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cnu_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnu_sched
// Brief    : Self-checking bench for cnu_sched with a cycle-level reference
//            model built from row-count / write-back-time rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnu_sched;

  localparam int ROWS    = 4;
  localparam int CNU_LAT = 2;
  localparam int ITER_W  = 6;
  localparam int ROW_W   = 2;
  localparam int DLY     = 1 + CNU_LAT;
  localparam int HMAX    = 4096;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_FIN  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              stall = 1'b0;
  logic [ITER_W-1:0] n_iter = '0;
  logic              rd_en;
  logic [ROW_W-1:0]  rd_addr;
  logic              cnu_vld;
  logic              wr_en;
  logic [ROW_W-1:0]  wr_addr;
  logic [ITER_W-1:0] iter_cnt;
  logic              busy;
  logic              done;

  cnu_sched #(
    .D       (8),
    .data_w  (8),
    .ROWS    (ROWS),
    .CNU_LAT (CNU_LAT),
    .ITER_W  (ITER_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n_iter   (n_iter),
    .stall    (stall),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .cnu_vld  (cnu_vld),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iter_cnt (iter_cnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rst_cyc  = -1;

  // reference model state
  int m_mode   = M_IDLE;
  int m_issued = 0;
  int m_iter   = 0;
  int m_niter  = 0;
  int m_resume = 0;
  bit h_rd   [HMAX];
  int h_addr [HMAX];

  int done_cyc   = -1;
  int done_total = 0;
  int busy_total = 0;
  int wr_total   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int past_rd(input int k);
    int i;
    i = cyc - k;
    if (i < 0 || i <= rst_cyc) return 0;
    return int'(h_rd[i]);
  endfunction

  function automatic int past_addr(input int k);
    int i;
    i = cyc - k;
    if (i < 0 || i <= rst_cyc) return 0;
    return h_addr[i];
  endfunction

  // One clock cycle: drive inputs, optionally pulse reset, check, advance model
  task automatic tick(input bit st, input int ni, input bit sl, input bit rst_pulse);
    bit e_rd;
    int e_addr;
    if (cyc >= HMAX) begin
      $display("FAIL history_overflow observed=%0d limit=%0d", cyc, HMAX);
      $fatal(1, "history overflow");
    end
    start  = st;
    n_iter = ITER_W'(ni);
    stall  = sl;
    if (rst_pulse) begin
      #1 rst = 1'b0;
      #1;
      chk("async_rst_rd_en",    rd_en,    0);
      chk("async_rst_rd_addr",  rd_addr,  0);
      chk("async_rst_cnu_vld",  cnu_vld,  0);
      chk("async_rst_wr_en",    wr_en,    0);
      chk("async_rst_wr_addr",  wr_addr,  0);
      chk("async_rst_iter_cnt", iter_cnt, 0);
      chk("async_rst_busy",     busy,     0);
      chk("async_rst_done",     done,     0);
      m_mode   = M_IDLE;
      m_iter   = 0;
      m_issued = 0;
      rst_cyc  = cyc;
      #1 rst = 1'b1;
    end
    @(negedge clk);
    e_rd        = (m_mode == M_RUN) && !sl;
    e_addr      = (m_mode == M_RUN) ? m_issued : 0;
    h_rd[cyc]   = e_rd;
    h_addr[cyc] = e_addr;
    chk("rd_en",    rd_en,    e_rd);
    chk("rd_addr",  rd_addr,  e_addr);
    chk("cnu_vld",  cnu_vld,  past_rd(1));
    chk("wr_en",    wr_en,    past_rd(DLY));
    chk("wr_addr",  wr_addr,  past_addr(DLY));
    chk("iter_cnt", iter_cnt, m_iter);
    chk("busy",     busy,     m_mode != M_IDLE);
    chk("done",     done,     m_mode == M_FIN);
    if (done === 1'b1) begin
      done_cyc = cyc;
      done_total++;
    end
    if (busy === 1'b1) busy_total++;
    if (wr_en === 1'b1) wr_total++;
    @(posedge clk);
    case (m_mode)
      M_IDLE: begin
        if (st) begin
          m_iter = 0;
          if ((ni % 64) == 0) begin
            m_mode = M_FIN;
          end else begin
            m_niter  = ni % 64;
            m_issued = 0;
            m_mode   = M_RUN;
          end
        end
      end
      M_RUN: begin
        if (!sl) begin
          m_issued++;
          if (m_issued == ROWS) begin
            // last row's write lands DLY cycles later; resume the cycle after it
            m_resume = cyc + DLY + 1;
            m_issued = 0;
            m_mode   = M_WAIT;
          end
        end
      end
      M_WAIT: begin
        if (cyc + 1 == m_resume) begin
          if (m_iter + 1 < m_niter) begin
            m_iter++;
            m_mode = M_RUN;
          end else begin
            m_mode = M_FIN;
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
    cyc++;
    #1;
  endtask

  // A start at relative cycle 0, fixed run length, with stall mask and optional re-start
  task automatic decode(input int ni, input logic [31:0] smask, input int restart_at,
                        input int ncyc, output int d_rel, output int d_cnt, output int b_cnt);
    int s0, dt0, bt0;
    s0  = cyc;
    dt0 = done_total;
    bt0 = busy_total;
    done_cyc = -1;
    for (int r = 0; r < ncyc; r++) begin
      tick((r == 0) || (r == restart_at), ni, smask[r], 1'b0);
    end
    d_rel = (done_cyc < 0) ? -1 : done_cyc - s0;
    d_cnt = done_total - dt0;
    b_cnt = busy_total - bt0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_rel, d_cnt, b_cnt, wr0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_en",    rd_en,    0);
    chk("reset_rd_addr",  rd_addr,  0);
    chk("reset_cnu_vld",  cnu_vld,  0);
    chk("reset_wr_en",    wr_en,    0);
    chk("reset_wr_addr",  wr_addr,  0);
    chk("reset_iter_cnt", iter_cnt, 0);
    chk("reset_busy",     busy,     0);
    chk("reset_done",     done,     0);
    @(posedge clk);
    #1 rst = 1'b1;

    // single iteration, no stall: done 8 cycles after start
    decode(1, 32'h0, -1, 30, d_rel, d_cnt, b_cnt);
    chk("one_iter_done_cycle", d_rel, 8);
    chk("one_iter_done_count", d_cnt, 1);

    // two iterations: done at 15, iter_cnt keeps final value
    decode(2, 32'h0, -1, 30, d_rel, d_cnt, b_cnt);
    chk("two_iter_done_cycle", d_rel, 15);
    chk("two_iter_final_iter", iter_cnt, 1);

    // stall on cycles 2-3: done slips to 10
    decode(1, 32'h0000_000C, -1, 30, d_rel, d_cnt, b_cnt);
    chk("stall_done_cycle", d_rel, 10);

    // zero iterations: immediate done, busy for one cycle
    decode(0, 32'h0, -1, 30, d_rel, d_cnt, b_cnt);
    chk("zero_iter_done_cycle", d_rel, 1);
    chk("zero_iter_busy_cycles", b_cnt, 1);
    chk("zero_iter_wr_free_iter", iter_cnt, 0);

    // reset pulsed in cycle 5 of a decode: no further write-backs
    tick(1'b1, 1, 1'b0, 1'b0);
    for (int r = 1; r < 5; r++) tick(1'b0, 1, 1'b0, 1'b0);
    wr0 = wr_total;
    tick(1'b0, 1, 1'b0, 1'b1);
    for (int r = 0; r < 10; r++) tick(1'b0, 1, 1'b0, 1'b0);
    chk("no_wr_after_reset", wr_total - wr0, 0);
    decode(1, 32'h0, -1, 30, d_rel, d_cnt, b_cnt);
    chk("post_reset_done_cycle", d_rel, 8);

    // start re-asserted while running is ignored
    decode(1, 32'h0, 2, 30, d_rel, d_cnt, b_cnt);
    chk("restart_done_count", d_cnt, 1);
    chk("restart_done_cycle", d_rel, 8);

    // randomized decodes with random stalls and stray start/n_iter activity
    for (int k = 0; k < 12; k++) begin
      int ni, r;
      ni = int'($urandom_range(0, 3));
      r  = 0;
      tick(1'b1, ni, ($urandom_range(0, 3) == 0), 1'b0);
      while (m_mode != M_IDLE && r < 200) begin
        tick(($urandom_range(0, 7) == 0), int'($urandom_range(0, 63)),
             ($urandom_range(0, 3) == 0), 1'b0);
        r++;
      end
      chk("rand_decode_ends_idle", busy, 0);
      repeat (2) tick(1'b0, int'($urandom_range(0, 63)), ($urandom_range(0, 1) == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cnu_sched.md
CNU_SCHED -- requirements
Module: cnu_sched

Interface
REQ-001 Parameter D, default 8: check-node degree; passed through to sizing only.
REQ-002 Parameter data_w, default 8: message width; passed through to sizing only.
REQ-003 Parameter ROWS, default 16: check-node rows per iteration; ROW_W = ceil(log2(ROWS)), minimum 1.
REQ-004 Parameter CNU_LAT, default 2: cycles from CNU input valid to CNU output valid; must be at least 1.
REQ-005 Parameter ITER_W, default 6: iteration-count width.
REQ-006 clk  input  1: single clock; all state updates on the rising edge.
REQ-007 rst  input  1: reset; asynchronous, active-low.
REQ-008 start  input  1: single-cycle request to begin a decode; sampled in IDLE only.
REQ-009 n_iter  input  ITER_W: iteration count; captured with start.
REQ-010 stall  input  1: message-memory busy; blocks new row issue.
REQ-011 rd_en  output  1: read strobe for the Q message memory.
REQ-012 rd_addr  output  ROW_W: row being read.
REQ-013 cnu_vld  output  1: CNU input valid; equals rd_en delayed 1 cycle (1-cycle memory read latency).
REQ-014 wr_en  output  1: write-back strobe for the R results.
REQ-015 wr_addr  output  ROW_W: row being written back.
REQ-016 iter_cnt  output  ITER_W: index of the current iteration, counting from 0.
REQ-017 busy  output  1: high in every state except IDLE.
REQ-018 done  output  1: one-cycle completion pulse.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE: start=1 with n_iter>0 captures n_iter and moves to RUN; start=1 with n_iter=0 moves directly to DONE, issuing no reads.
REQ-021 RUN: rd_en = !stall (combinational); each issue sends rd_addr; the row counter increments on each issue.
REQ-022 RUN: the issue of row ROWS-1 moves the FSM to DRAIN; the row counter wraps to 0.
REQ-023 stall: while high, no issue occurs and rd_addr holds; in-flight pipeline stages (cnu_vld, wr_en) keep advancing.
REQ-024 Write-back: wr_en and wr_addr equal rd_en and rd_addr delayed by exactly 1+CNU_LAT cycles, through a valid/address shift register.
REQ-025 DRAIN: no reads are issued; the FSM waits until no issue is in flight.
REQ-026 DRAIN exit: the cycle after the last wr_en of the iteration, go to RUN with iter_cnt+1 if iter_cnt+1 < n_iter; otherwise go to DONE.
REQ-027 Iteration boundary: the next iteration's row 0 is never read before the previous iteration's last write (layer-hazard rule).
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; iter_cnt holds its final value until the next start.
REQ-029 start is ignored in RUN, DRAIN and DONE; no queuing.
REQ-030 Counters: all counter arithmetic is unsigned and wraps modulo 2^width; the row counter never exceeds ROWS-1.

Reset
REQ-031 rst=0 asynchronously forces IDLE and clears every output, counter and shift stage to 0, including mid-operation.
REQ-032 After a reset in RUN or DRAIN, no further wr_en is produced for the aborted decode.

Structure
REQ-033 The FSM state enumeration and ceil-log2 function live in the shared LDPC decoder package, alongside the cnu sizing.
REQ-034 One sub-module, cnu_dly_line, is parameterised by depth and width and carries {valid, addr} for the 1+CNU_LAT delay.
REQ-035 There is no other hierarchy; the CNU itself is instantiated by the parent, not inside this block.

Verification
REQ-036 ROWS=4, CNU_LAT=2, n_iter=1, stall=0, start at cycle 0 -> rd_en cycles 1-4 with addr 0-3; cnu_vld cycles 2-5; wr_en cycles 4-7 with addr 0-3; done at cycle 8.
REQ-037 Same setup with n_iter=2 -> second-iteration rd_en at cycles 8-11 with iter_cnt=1; last wr_en at cycle 14; done at cycle 15.
REQ-038 stall=1 on cycles 2-3 of REQ-036 -> issues at cycles 1, 4, 5, 6; wr_addr sequence 0-3 at cycles 4, 7, 8, 9; done at cycle 10.
REQ-039 start with n_iter=0 -> no rd_en or wr_en; done exactly 1 cycle after start; busy high for exactly that 1 cycle.
REQ-040 rst pulsed low in cycle 5 of REQ-036 -> all outputs 0 within that cycle; no wr_en thereafter; a new start decodes normally.
REQ-041 start re-asserted during RUN -> ignored; exactly one done pulse results.
